// File: rtl/item_spawner.sv
// Level item placer: draws X/Y/type from the LFSR byte stream, rejects
// out-of-range or overlapping candidates, and writes the item table.
module item_spawner #(
  parameter int NUM_ITEMS = 8,
  parameter int X_SPAN    = 160,
  parameter int Y_MIN     = 40,
  parameter int Y_MAX     = 119,
  parameter int MIN_SEP   = 16,
  parameter int MAX_TRIES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   rand_in,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_en,
  output logic [$clog2(NUM_ITEMS)-1:0] wr_addr,
  output logic [7:0]                   wr_x,
  output logic [6:0]                   wr_y,
  output logic [1:0]                   wr_type,
  output logic                         wr_valid
);

  localparam int AW = $clog2(NUM_ITEMS);
  localparam int TW = $clog2(MAX_TRIES);
  localparam logic [7:0]    XS   = 8'(X_SPAN);
  localparam logic [6:0]    YLO  = 7'(Y_MIN);
  localparam logic [6:0]    YHI  = 7'(Y_MAX);
  localparam logic [8:0]    SEP  = 9'(MIN_SEP);
  localparam logic [AW-1:0] LAST = AW'(NUM_ITEMS - 1);
  localparam logic [TW-1:0] LTRY = TW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_X, S_GET_Y, S_GET_T, S_CHECK, S_WRITE, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  att_q, att_d;
  logic [7:0]     cx_q, cx_d;
  logic [6:0]     cy_q, cy_d;
  logic [1:0]     ct_q, ct_d;
  logic           ok_q, ok_d;
  logic [7:0]     px_q [NUM_ITEMS];
  logic [7:0]     px_d [NUM_ITEMS];
  logic [6:0]     py_q [NUM_ITEMS];
  logic [6:0]     py_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] pv_q, pv_d;

  logic [8:0] dx, dy, adx, ady;
  logic       conflict, rej;

  // Differences are taken one bit wider so the magnitude never wraps.
  always_comb begin
    dx  = {1'b0, cx_q} - {1'b0, px_q[idx_q]};
    dy  = {2'b0, cy_q} - {2'b0, py_q[idx_q]};
    adx = dx[8] ? (9'd0 - dx) : dx;
    ady = dy[8] ? (9'd0 - dy) : dy;
    conflict = pv_q[idx_q] && (adx < SEP) && (ady < SEP);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    att_d   = att_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ct_d    = ct_q;
    ok_d    = ok_q;
    px_d    = px_q;
    py_d    = py_q;
    pv_d    = pv_q;
    rej     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GET_X;
          cnt_d   = '0;
          att_d   = '0;
          pv_d    = '0;
        end
      end
      S_GET_X: begin
        if (rand_in < XS) begin
          cx_d    = rand_in;
          state_d = S_GET_Y;
        end else begin
          rej = 1'b1;
        end
      end
      S_GET_Y: begin
        if (rand_in[6:0] >= YLO && rand_in[6:0] <= YHI) begin
          cy_d    = rand_in[6:0];
          state_d = S_GET_T;
        end else begin
          rej = 1'b1;
        end
      end
      S_GET_T: begin
        ct_d    = rand_in[1:0];
        idx_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cnt_q == '0) begin
          ok_d    = 1'b1;
          state_d = S_WRITE;
        end else if (conflict) begin
          rej = 1'b1;
        end else if (idx_q == cnt_q - AW'(1)) begin
          ok_d    = 1'b1;
          state_d = S_WRITE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_WRITE: begin
        px_d[cnt_q] = cx_q;
        py_d[cnt_q] = cy_q;
        pv_d[cnt_q] = ok_q;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + AW'(1);
          att_d   = '0;
          state_d = S_GET_X;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rej) begin
      if (att_q == LTRY) begin
        ok_d    = 1'b0;
        state_d = S_WRITE;
      end else begin
        att_d   = att_q + TW'(1);
        state_d = S_GET_X;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      att_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ct_q    <= '0;
      ok_q    <= 1'b0;
      px_q    <= '{default: '0};
      py_q    <= '{default: '0};
      pv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      att_q   <= att_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ct_q    <= ct_d;
      ok_q    <= ok_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pv_q    <= pv_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_en    = (state_q == S_WRITE);
  assign wr_addr  = wr_en ? cnt_q : '0;
  assign wr_x     = wr_en ? cx_q : '0;
  assign wr_y     = wr_en ? cy_q : '0;
  assign wr_type  = wr_en ? ct_q : '0;
  assign wr_valid = wr_en & ok_q;

endmodule

// File: tb/tb_item_spawner.sv
// Bench for item_spawner: per-cycle byte streams checked against a
// slot-by-slot placement model that predicts every write and its cycle.
module tb_item_spawner;

  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] rand_in;
  logic       busy, done, wr_en, wr_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [1:0] wr_type;

  item_spawner dut (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type), .wr_valid(wr_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] rnd [MAXC];
  bit ew [MAXC];
  bit ev [MAXC];
  int ea [MAXC];
  int ex [MAXC];
  int ey [MAXC];
  int et [MAXC];
  int done_c, chk3_c;
  logic [7:0] lf = 8'hA5;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic gen(int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0: rnd[c] = 8'($urandom);
        1: rnd[c] = 8'($urandom_range(40, 90));
        2: rnd[c] = 8'd200;
        3: rnd[c] = (c % 3 == 0) ? 8'd10 : (c % 3 == 1) ? 8'd50 : 8'd2;
        4: rnd[c] = (c == 0) ? 8'd10 : (c == 1) ? 8'd50 :
                    (c == 2) ? 8'd2 : 8'($urandom);
        5: begin
          lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
          rnd[c] = lf;
        end
        default: rnd[c] = 8'd50;
      endcase
    end
  endtask

  // Walk the stream one consumed byte per cycle, slot by slot.
  task automatic run_model();
    int t = 0;
    int tx [8];
    int ty [8];
    bit tv [8];
    int cx = 0, cy = 0, ct = 0;
    chk3_c = -1;
    for (int c = 0; c < MAXC; c++) ew[c] = 0;
    for (int s = 0; s < 8; s++) begin
      int tries = 0;
      bit ok = 0;
      while (1) begin
        bit rej = 0;
        int v;
        v = int'(rnd[t]); t++;
        if (v >= 160) rej = 1;
        else begin
          cx = v;
          v = int'(rnd[t]) % 128; t++;
          if (v < 40 || v > 119) rej = 1;
          else begin
            cy = v;
            ct = int'(rnd[t]) % 4; t++;
            if (s == 3 && chk3_c < 0) chk3_c = t;
            if (s == 0) t++;
            else begin
              for (int j = 0; j < s; j++) begin
                t++;
                if (tv[j] && iabs(cx - tx[j]) < 16 && iabs(cy - ty[j]) < 16) begin
                  rej = 1;
                  break;
                end
              end
            end
            if (!rej) begin
              ok = 1;
              break;
            end
          end
        end
        if (rej) begin
          if (tries == 15) break;
          tries++;
        end
      end
      ew[t] = 1; ea[t] = s; ev[t] = ok;
      ex[t] = cx; ey[t] = cy; et[t] = ct;
      tx[s] = cx; ty[s] = cy; tv[s] = ok;
      t++;
    end
    done_c = t;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_x"}, 32'(wr_x), 0);
    chk({tag, "_wr_y"}, 32'(wr_y), 0);
    chk({tag, "_wr_type"}, 32'(wr_type), 0);
  endtask

  task automatic run_level(int mode, bit pulse_busy, bit rst_chk3, bit start_done);
    int nw = 0, nd = 0;
    gen(mode);
    run_model();
    if (mode == 5) repeat ($urandom_range(1, 1000)) @(posedge clk);
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c <= done_c + 1; c++) begin
      rand_in = rnd[c];
      start = (pulse_busy && (c == 3 || c == done_c - 1)) ||
              (start_done && c == done_c);
      chk("busy", 32'(busy), (c <= done_c) ? 1 : 0);
      chk("done", 32'(done), (c == done_c) ? 1 : 0);
      chk("wr_en", 32'(wr_en), ew[c] ? 1 : 0);
      nw += int'(wr_en);
      nd += int'(done);
      if (ew[c]) begin
        chk("wr_addr", 32'(wr_addr), ea[c]);
        chk("wr_valid", 32'(wr_valid), ev[c] ? 1 : 0);
        if (ev[c]) begin
          chk("wr_x", 32'(wr_x), ex[c]);
          chk("wr_y", 32'(wr_y), ey[c]);
          chk("wr_type", 32'(wr_type), et[c]);
        end
      end
      if (rst_chk3 && c == chk3_c) begin
        #2 rst = 1;
        #1 chk_zero("midrst");
        #1 rst = 0;
        start = 0;
        @(posedge clk); #1;
        chk("midrst_idle", 32'(busy), 0);
        return;
      end
      @(posedge clk); #1;
    end
    start = 0;
    chk("num_writes", 32'(nw), 8);
    chk("num_done", 32'(nd), 1);
    if (start_done) chk("no_restart", 32'(busy), 0);
  endtask

  initial begin
    rst = 1;
    start = 0;
    rand_in = 8'd0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 0;
    run_level(4, 0, 0, 0);
    run_level(2, 0, 0, 0);
    run_level(3, 0, 0, 0);
    run_level(6, 0, 0, 0);
    run_level(0, 1, 0, 0);
    run_level(1, 0, 0, 0);
    run_level(1, 0, 1, 0);
    run_level(4, 0, 0, 0);
    run_level(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) run_level(5, 0, 0, 0);
    run_level(1, 1, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
